// File: rtl/if_prefetch_pkg.sv
// Shared defaults, entry type and sizing helper for the instruction prefetch unit.
package if_pkg;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INST_W   = 32;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;
  localparam int          DEF_PC_STEP  = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } if_entry_t;

  // Occupancy must represent 0..depth inclusive, hence one bit above the pointer width.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-side bus: ROM request/response, redirect and the decode handshake.
interface if_prefetch_if
  import if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W,
  parameter int DEPTH  = DEF_DEPTH
);

  logic                      rom_ce_o;
  logic [ADDR_W-1:0]         rom_addr_o;
  logic [INST_W-1:0]         rom_data_i;
  logic                      redirect_i;
  logic [ADDR_W-1:0]         redirect_pc_i;
  logic                      inst_valid_o;
  logic                      inst_ready_i;
  logic [INST_W-1:0]         inst_o;
  logic [ADDR_W-1:0]         pc_o;
  logic [count_w(DEPTH)-1:0] count_o;

  modport master (
    output rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o, count_o,
    input  rom_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o, count_o,
    output rom_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO with flush; head entry is presented combinationally on dout.
module if_fifo
  import if_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int CW = count_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch unit: PC sequencing, one-deep in-flight read tracking and
// credit-checked prefetch into a FIFO, with redirect flushing everything.
module if_prefetch
  import if_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = DEF_PC_STEP
) (
  input  logic          clk,
  input  logic          rst,
  if_prefetch_if.master bus
);

  localparam int CW = count_w(DEPTH);

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        pend_pc;
  logic                     pend;
  logic [CW-1:0]            count;
  logic                     req;
  logic                     push;
  logic                     pop;
  logic [ADDR_W+INST_W-1:0] head;

  // Credit counts the in-flight read so its data always has a slot, even with no pop.
  assign req  = !rst && !bus.redirect_i &&
                (({1'b0, count} + (CW+1)'(pend)) < (CW+1)'(DEPTH));
  assign push = pend && !bus.redirect_i;
  assign pop  = bus.inst_valid_o && bus.inst_ready_i;

  assign bus.rom_ce_o     = req;
  assign bus.rom_addr_o   = fetch_pc;
  assign bus.inst_valid_o = (count != '0) && !bus.redirect_i;
  assign bus.pc_o         = head[ADDR_W+INST_W-1:INST_W];
  assign bus.inst_o       = head[INST_W-1:0];
  assign bus.count_o      = count;

  if_fifo #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_i),
    .din   ({pend_pc, bus.rom_data_i}),
    .dout  (head),
    .count (count)
  );

  // Redirect reloads the PC and drops the read whose data lands this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pend     <= 1'b0;
      pend_pc  <= '0;
    end else if (bus.redirect_i) begin
      fetch_pc <= bus.redirect_pc_i;
      pend     <= 1'b0;
    end else begin
      pend <= req;
      if (req) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        pend_pc  <= fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench: cycle-exact vector table on DEPTH=4, PC wrap on ADDR_W=8,
// randomized scoreboard on DEPTH=2/4/8, and a mid-stream asynchronous reset.
module tb_if_prefetch;
  import if_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_prefetch_if #(.DEPTH(2))              b2 ();
  if_prefetch_if #(.DEPTH(4))              b4 ();
  if_prefetch_if #(.DEPTH(8))              b8 ();
  if_prefetch_if #(.ADDR_W(8), .DEPTH(4))  bw ();

  if_prefetch #(.DEPTH(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  if_prefetch #(.DEPTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  if_prefetch #(.DEPTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  if_prefetch #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hF8)) uw (.clk(clk), .rst(rst), .bus(bw));

  // Registered ROM models: data = addr ^ A5A5_0000.
  always @(posedge clk) if (b2.rom_ce_o) b2.rom_data_i <= b2.rom_addr_o ^ 32'hA5A5_0000;
  always @(posedge clk) if (b4.rom_ce_o) b4.rom_data_i <= b4.rom_addr_o ^ 32'hA5A5_0000;
  always @(posedge clk) if (b8.rom_ce_o) b8.rom_data_i <= b8.rom_addr_o ^ 32'hA5A5_0000;
  always @(posedge clk) if (bw.rom_ce_o) bw.rom_data_i <= {24'h0, bw.rom_addr_o} ^ 32'hA5A5_0000;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] addr;
    int          cnt;
  } vec_t;

  vec_t        tbl [29];
  logic [31:0] nxt [3];
  int          hs  [3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    b2.inst_ready_i = rdy; b2.redirect_i = rd; b2.redirect_pc_i = rpc;
    b4.inst_ready_i = rdy; b4.redirect_i = rd; b4.redirect_pc_i = rpc;
    b8.inst_ready_i = rdy; b8.redirect_i = rd; b8.redirect_pc_i = rpc;
    #1;
  endtask

  // Architectural model: the next delivered pc follows the last redirect target in steps of 4.
  task automatic scoreboard(input int i, input int depth, input logic valid, input logic [31:0] pc,
                            input logic [31:0] inst, input int cnt, input logic rdy,
                            input logic rd, input logic [31:0] rpc);
    checkOutput($sformatf("d%0d count<=depth", depth), 32'(cnt <= depth), 32'd1);
    if (rd) begin
      checkOutput($sformatf("d%0d valid during redirect", depth), 32'(valid), 32'd0);
      nxt[i] = rpc;
    end else if (valid && rdy) begin
      checkOutput($sformatf("d%0d delivered pc", depth), pc, nxt[i]);
      checkOutput($sformatf("d%0d delivered inst", depth), inst, nxt[i] ^ 32'hA5A5_0000);
      nxt[i] = pc + 32'd4;
      hs[i]++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int first;
    logic r, d;
    logic [31:0] rpc;
    logic [7:0]  wexp;

    tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b1, 32'h8,   1};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b1, 32'hC,   2};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3};
    for (int c = 5; c < 12; c++)
      tbl[c] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,   1'b0, 32'h0,   4};
    tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   4};
    tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h10,  3};
    tbl[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h14,  2};
    tbl[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h18,  2};
    tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h1C,  2};
    tbl[17] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   3};
    tbl[18] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 0};
    tbl[19] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104, 0};
    tbl[20] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h108, 1};
    tbl[21] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h10C, 1};
    tbl[22] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h110, 1};
    tbl[23] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1};
    tbl[24] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 32'h0,   0};
    tbl[25] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300, 0};
    tbl[26] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h304, 0};
    tbl[27] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 32'h308, 1};
    tbl[28] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h304, 1'b1, 32'h30C, 1};

    bw.inst_ready_i = 1'b1; bw.redirect_i = 1'b0; bw.redirect_pc_i = 8'h0;
    b2.inst_ready_i = 1'b1; b2.redirect_i = 1'b0; b2.redirect_pc_i = 32'h0;
    b4.inst_ready_i = 1'b1; b4.redirect_i = 1'b0; b4.redirect_pc_i = 32'h0;
    b8.inst_ready_i = 1'b1; b8.redirect_i = 1'b0; b8.redirect_pc_i = 32'h0;

    #1 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset rom_ce",     32'(b4.rom_ce_o),     32'd0);
    checkOutput("reset inst_valid", 32'(b4.inst_valid_o), 32'd0);
    checkOutput("reset count",      32'(b4.count_o),      32'd0);
    checkOutput("reset pc",         b4.pc_o,              32'h0);
    checkOutput("reset inst",       b4.inst_o,            32'h0);
    @(posedge clk); #2 rst = 1'b0;

    $display("[TB] vector table: reset release, stall, redirects");
    for (int c = 0; c < 29; c++) begin
      applyStimulus(tbl[c].ready, tbl[c].redir, tbl[c].rpc);
      checkOutput($sformatf("c%0d inst_valid", c), 32'(b4.inst_valid_o), 32'(tbl[c].valid));
      checkOutput($sformatf("c%0d rom_ce", c),     32'(b4.rom_ce_o),     32'(tbl[c].ce));
      checkOutput($sformatf("c%0d count", c),      32'(b4.count_o),      32'(tbl[c].cnt));
      if (tbl[c].valid) begin
        checkOutput($sformatf("c%0d pc", c),   b4.pc_o,   tbl[c].pc);
        checkOutput($sformatf("c%0d inst", c), b4.inst_o, tbl[c].pc ^ 32'hA5A5_0000);
      end
      if (tbl[c].ce)
        checkOutput($sformatf("c%0d rom_addr", c), b4.rom_addr_o, tbl[c].addr);
      if (c >= 2 && c <= 5) begin
        wexp = 8'hF8 + 8'(4 * (c - 2));
        checkOutput($sformatf("wrap c%0d valid", c), 32'(bw.inst_valid_o), 32'd1);
        checkOutput($sformatf("wrap c%0d pc", c),    32'(bw.pc_o),         32'(wexp));
      end
    end

    $display("[TB] randomized scoreboard on DEPTH 2/4/8");
    @(negedge clk); rst = 1'b1;
    b2.redirect_i = 1'b0; b4.redirect_i = 1'b0; b8.redirect_i = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin nxt[i] = 32'h0; hs[i] = 0; end
    for (int n = 0; n < 1000; n++) begin
      r   = 1'($urandom_range(1));
      d   = ($urandom_range(99) < 5);
      rpc = $urandom & 32'hFFFF_FFFC;
      applyStimulus(r, d, rpc);
      scoreboard(0, 2, b2.inst_valid_o, b2.pc_o, b2.inst_o, int'(b2.count_o), r, d, rpc);
      scoreboard(1, 4, b4.inst_valid_o, b4.pc_o, b4.inst_o, int'(b4.count_o), r, d, rpc);
      scoreboard(2, 8, b8.inst_valid_o, b8.pc_o, b8.inst_o, int'(b8.count_o), r, d, rpc);
    end
    checkOutput("d2 throughput", 32'(hs[0] > 100), 32'd1);
    checkOutput("d4 throughput", 32'(hs[1] > 100), 32'd1);
    checkOutput("d8 throughput", 32'(hs[2] > 100), 32'd1);

    $display("[TB] asynchronous reset mid-stream");
    @(negedge clk); rst = 1'b1;
    b2.redirect_i = 1'b0; b4.redirect_i = 1'b0; b8.redirect_i = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("pre-reset count",  32'(b4.count_o),  32'd3);
    checkOutput("pre-reset rom_ce", 32'(b4.rom_ce_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset rom_ce",     32'(b4.rom_ce_o),     32'd0);
    checkOutput("async reset inst_valid", 32'(b4.inst_valid_o), 32'd0);
    checkOutput("async reset count",      32'(b4.count_o),      32'd0);
    checkOutput("async reset pc",         b4.pc_o,              32'h0);
    checkOutput("async reset inst",       b4.inst_o,            32'h0);
    @(posedge clk); #2 rst = 1'b0;
    k = 0;
    first = -1;
    for (int c = 0; c < 12 && k < 2; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (b4.inst_valid_o) begin
        if (first < 0) first = c;
        checkOutput($sformatf("restart pc %0d", k), b4.pc_o, 32'(4 * k));
        k++;
      end
    end
    checkOutput("restart first valid cycle", 32'(first), 32'd2);
    checkOutput("restart handshakes",        32'(k),     32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
